sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like data bus between two requesters.
- Requester 0 is the instruction-fetch port; requester 1 is the data port, fed by the load/store byte-select logic (wstrb/size/wdata already aligned).
- Grants one requester at a time, latches its request, sequences the address and data phases, and routes the handshakes and read data back to the owner.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch request (held until i_addr_ok).
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  fetch address accepted.
- i_data_ok  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request (held until d_addr_ok).
- d_wr  in  1  1 = store.
- d_size  in  2  0 = byte, 1 = half, 2 = word.
- d_wstrb  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_addr_ok  out  1  data address accepted.
- d_data_ok  out  1  data response (load data or store ack).
- d_rdata  out  DATA_W  load read data.
- m_req  out  1  bus request.
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  latched request fields.
- m_addr_ok  in  1  bus address accepted.
- m_data_ok  in  1  bus response.
- m_rdata  in  DATA_W  bus read data.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ADDR, DATA. A 1-bit owner register tracks the granted requester (0 = fetch, 1 = data).
- IDLE:
  - If d_req or i_req is high, grant at the clock edge and go to ADDR.
  - Latch the owner's fields into m_* registers. Fetch is forced to wr = 0, size = 2, wstrb = 0, wdata = 0.
  - Default priority: data beats fetch when both requests are high.
- ADDR:
  - m_req = 1.
  - On m_addr_ok: assert the owner's *_addr_ok in the same cycle (combinational) and go to DATA.
- DATA:
  - m_req = 0.
  - On m_data_ok: assert the owner's *_data_ok in the same cycle, drive the owner's *_rdata = m_rdata, and go to IDLE.
- m_addr_ok and m_data_ok in the same ADDR cycle: both owner pulses fire and the FSM goes directly to IDLE.
- m_data_ok while in IDLE or ADDR with no accepted address: ignored, no pulse.
- The non-owner's addr_ok/data_ok are always 0. The non-owner's rdata and an idle owner's rdata are 0.
- One bubble cycle in IDLE between transactions. Minimum occupancy is 3 cycles per access with zero bus wait states.
- Requests arriving while busy are not acknowledged; the requester holds req until its addr_ok.
- Reset:
  - On resetn low: state = IDLE, owner = 0, all m_* registers = 0, m_req = 0, busy = 0, all *_ok = 0, all rdata = 0.
  - This applies even mid-transaction. A stale m_data_ok after reset is ignored.
- m_* outputs stay stable from the grant until the return to IDLE. Requester inputs changing after the grant have no effect.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register (reset 0) is updated at each grant.
  - On simultaneous requests, the requester that is not last_owner wins, so back-to-back contention alternates.
  - A lone request is granted regardless of last_owner.
- Undefined: fixed priority, data over fetch; no last_owner register.

Test Plan:
- Single fetch:
  - Stimulus: i_req = 1, i_addr = 0xBFC00000; bus asserts m_addr_ok 1 cycle after m_req and m_data_ok the next cycle with m_rdata = 0x3C1D8000.
  - Required: m_wr = 0, m_size = 2; i_addr_ok pulses 1 cycle; then i_data_ok = 1 with i_rdata = 0x3C1D8000; d_* outputs stay 0.
- Byte store:
  - Stimulus: d_req = 1, d_wr = 1, d_size = 0, d_wstrb = 0x4, d_addr = 0x80000402, d_wdata = 0x5A5A5A5A.
  - Required: m_* carry exactly these values; d_addr_ok pulses, then d_data_ok pulses; m_wdata is unchanged after the inputs change post-grant.
- Contention:
  - Stimulus: i_req and d_req both high from reset, held.
  - Required (fixed priority): data is served first, then fetch after its bubble.
  - Required with ARB_ROUND_ROBIN_EN: grants alternate data, fetch, data over 3 transactions.
- Wait states:
  - Stimulus: m_addr_ok delayed 3 cycles, m_data_ok delayed 4 cycles.
  - Required: m_req is high exactly 4 cycles (3 wait + accept cycle); busy stays high until the data_ok cycle; no early pulses.
- Same-cycle ok:
  - Stimulus: m_addr_ok and m_data_ok high together in ADDR.
  - Required: owner addr_ok and data_ok both pulse that cycle; state is IDLE the next cycle.
- Reset mid-op:
  - Stimulus: resetn low for 1 cycle while in DATA, then m_data_ok = 1 with no request pending.
  - Required: all outputs 0, busy = 0, no data_ok pulse to either requester.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// Handshake bundle between the fetch port, the data port, the shared SRAM-like bus and the arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface sram_like_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok;
    logic              i_data_ok;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [STRB_W-1:0] d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_wr;
    logic [1:0]        m_size;
    logic [STRB_W-1:0] m_wstrb;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_addr_ok;
    logic              m_data_ok;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output i_addr_ok, i_data_ok, i_rdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  i_addr_ok, i_data_ok, i_rdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  busy
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like bus between the fetch port (owner 0) and the data port (owner 1).
// Optional macro ARB_ROUND_ROBIN_EN: contention alternates owners instead of data-over-fetch.
module sram_like_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk,
    input logic                 resetn,
    sram_like_arbiter_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic grant_c;
    logic grant_owner_c;
    logic addr_fire_c;
    logic data_fire_c;

    assign grant_c = (state == IDLE) && (bus.i_req || bus.d_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    // On contention the requester that did not win last time is served.
    assign grant_owner_c = (bus.i_req && bus.d_req) ? ~last_owner : bus.d_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      last_owner <= 1'b0;
        else if (grant_c) last_owner <= grant_owner_c;
    end
`else
    assign grant_owner_c = bus.d_req;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_c) state_nxt = ADDR;
            ADDR:    if (bus.m_addr_ok) state_nxt = bus.m_data_ok ? IDLE : DATA;
            DATA:    if (bus.m_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once at grant and held until the return to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_c) begin
            owner <= grant_owner_c;
            if (grant_owner_c) begin
                wr_q    <= bus.d_wr;
                size_q  <= bus.d_size;
                wstrb_q <= bus.d_wstrb;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else begin
                wr_q    <= 1'b0;
                size_q  <= 2'd2;
                wstrb_q <= '0;
                addr_q  <= bus.i_addr;
                wdata_q <= '0;
            end
        end
    end

    // A data response counts only once the address has been accepted (possibly this cycle).
    assign addr_fire_c = (state == ADDR) && bus.m_addr_ok;
    assign data_fire_c = ((state == DATA) || addr_fire_c) && bus.m_data_ok;

    assign bus.i_addr_ok = addr_fire_c && !owner;
    assign bus.d_addr_ok = addr_fire_c && owner;
    assign bus.i_data_ok = data_fire_c && !owner;
    assign bus.d_data_ok = data_fire_c && owner;
    assign bus.i_rdata   = (data_fire_c && !owner) ? bus.m_rdata : '0;
    assign bus.d_rdata   = (data_fire_c && owner)  ? bus.m_rdata : '0;

    assign bus.m_req   = (state == ADDR);
    assign bus.m_wr    = wr_q;
    assign bus.m_size  = size_q;
    assign bus.m_wstrb = wstrb_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.busy    = (state != IDLE);
endmodule
